// File: rtl/occ_if.sv
`default_nettype none
// ============================================================================
// Module      : occ_if
// Description : Symbol-stream and Occ-row write bundle for occ_table_builder.
//               OCC_STATS_EN adds the total_syms / rows_written statistics.
// Revision    : 1.0 - initial release
// ============================================================================
interface occ_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              sym_valid;
    logic [1:0]        sym_data;
    logic              sym_last;
    logic              sym_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [255:0]      wr_data;
    logic              busy;
    logic              done;
    logic              err;
`ifdef OCC_STATS_EN
    logic [31:0]       total_syms;
    logic [ADDR_W:0]   rows_written;
`endif

    modport master (
        output start, sym_valid, sym_data, sym_last,
        input  sym_ready, wr_en, wr_addr, wr_data, busy, done, err
`ifdef OCC_STATS_EN
        , input total_syms, rows_written
`endif
    );

    modport slave (
        input  start, sym_valid, sym_data, sym_last,
        output sym_ready, wr_en, wr_addr, wr_data, busy, done, err
`ifdef OCC_STATS_EN
        , output total_syms, rows_written
`endif
    );
endinterface
`default_nettype wire

// File: rtl/occ_table_builder.sv
`default_nettype none
// ============================================================================
// Module      : occ_table_builder
// Description : Streams 2-bit BWT symbols into 256-bit FM-index Occ rows
//               (counts + 64 packed symbols) and appends a totals row.
//               Optional macro OCC_STATS_EN adds symbol/row statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module occ_table_builder #(
    parameter int ADDR_W   = 8,
    parameter int MAX_ROWS = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    occ_if.slave      bus
);
    localparam logic [ADDR_W-1:0] c_max_row = ADDR_W'(MAX_ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_TERM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [255:0]      r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_last;
    logic [ADDR_W-1:0] r_row;
    logic [5:0]        r_idx;
    logic [127:0]      r_syms;
    // Index 0..3 = A,C,G,T, so the packed vector drops straight into [255:128].
    logic [3:0][31:0]  r_cnt;
    logic [3:0][31:0]  r_snap;
`ifdef OCC_STATS_EN
    logic [31:0]       r_total_syms;
    logic [ADDR_W:0]   r_rows_written;
`endif

    logic              w_xfer;
    logic              w_row_end;
    logic              w_row_ovf;
    logic [ADDR_W-1:0] w_row_inc;
    logic [127:0]      w_syms_next;
    logic [3:0][31:0]  w_cnt_next;

    always_comb begin
        w_xfer      = bus.sym_valid && r_ready;
        w_row_end   = (r_idx == 6'd63) || bus.sym_last;
        w_row_ovf   = (r_row == c_max_row);
        w_row_inc   = r_row + ADDR_W'(1);
        w_syms_next = r_syms;
        w_syms_next[{r_idx, 1'b0} +: 2] = bus.sym_data;
        w_cnt_next  = r_cnt;
        w_cnt_next[bus.sym_data] = r_cnt[bus.sym_data] + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_last    <= 1'b0;
            r_row     <= '0;
            r_idx     <= '0;
            r_syms    <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
`ifdef OCC_STATS_EN
            r_total_syms   <= '0;
            r_rows_written <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_FILL;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_last  <= 1'b0;
                        r_row   <= '0;
                        r_idx   <= '0;
                        r_syms  <= '0;
                        r_cnt   <= '0;
                        r_snap  <= '0;
`ifdef OCC_STATS_EN
                        r_total_syms   <= '0;
                        r_rows_written <= '0;
`endif
                    end
                end

                S_FILL: begin
                    if (w_xfer) begin
                        r_syms <= w_syms_next;
                        r_cnt  <= w_cnt_next;
                        r_idx  <= r_idx + 6'd1;
`ifdef OCC_STATS_EN
                        r_total_syms <= r_total_syms + 32'd1;
`endif
                        if (w_row_end) begin
                            r_ready <= 1'b0;
                            r_last  <= bus.sym_last;
                            if (w_row_ovf) begin
                                r_err   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state   <= S_WRITE;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_row;
                                r_wr_data <= {r_snap, w_syms_next};
`ifdef OCC_STATS_EN
                                r_rows_written <= r_rows_written + 1'b1;
`endif
                            end
                        end
                    end
                end

                S_WRITE: begin
                    r_wr_en   <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_data <= '0;
                    r_snap    <= r_cnt;
                    r_row     <= w_row_inc;
                    r_syms    <= '0;
                    r_idx     <= '0;
                    if (!r_last) begin
                        r_state <= S_FILL;
                        r_ready <= 1'b1;
                    end else if (w_row_inc == c_max_row) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // Terminal row: final totals with an empty symbol field.
                        r_state   <= S_TERM;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_row_inc;
                        r_wr_data <= {r_cnt, 128'd0};
`ifdef OCC_STATS_EN
                        r_rows_written <= r_rows_written + 1'b1;
`endif
                    end
                end

                S_TERM: begin
                    r_wr_en   <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_data <= '0;
                    r_row     <= w_row_inc;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b0;
                    r_wr_en   <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_data <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sym_ready = r_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
`ifdef OCC_STATS_EN
    assign bus.total_syms   = r_total_syms;
    assign bus.rows_written = r_rows_written;
`endif

endmodule
`default_nettype wire

// File: tb/tb_occ_table_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_occ_table_builder
// Description : Randomized self-checking bench for occ_table_builder against
//               a row-level reference model of the Occ table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_occ_table_builder;
    localparam int ADDR_W = 8;
    localparam int MAX_R  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    occ_if #(.ADDR_W(ADDR_W)) bus ();

    occ_table_builder #(.ADDR_W(ADDR_W), .MAX_ROWS(MAX_R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor
    logic [ADDR_W-1:0] cap_addr[$];
    logic [255:0]      cap_data[$];
    int                done_cnt, zero_viol, cyc, last_wr_cyc, done_cyc;

    always @(negedge clk) begin
        cyc++;
        if (bus.wr_en) begin
            cap_addr.push_back(bus.wr_addr);
            cap_data.push_back(bus.wr_data);
            last_wr_cyc = cyc;
        end else if (bus.wr_addr != '0 || bus.wr_data != '0) begin
            zero_viol++;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int syms[$];

    // Reference model: expected writes straight from the row-format rules.
    logic [ADDR_W-1:0] exp_addr[$];
    logic [255:0]      exp_data[$];
    bit                exp_err;
    int                exp_consumed;

    task automatic build_model(input int nsym);
        int ndata;
        int lim;
        int cnt[4];
        logic [255:0] row;
        exp_addr.delete();
        exp_data.delete();
        exp_err      = 1'b0;
        exp_consumed = nsym;
        ndata        = (nsym + 63) / 64;
        for (int r = 0; r <= ndata; r++) begin
            if (r >= MAX_R) begin
                exp_err = 1'b1;
                if (r < ndata) exp_consumed = (64 * r + 64 < nsym) ? 64 * r + 64 : nsym;
                break;
            end
            lim = (r == ndata) ? nsym : 64 * r;
            for (int s = 0; s < 4; s++) cnt[s] = 0;
            for (int i = 0; i < lim; i++) cnt[syms[i]]++;
            row = '0;
            for (int s = 0; s < 4; s++) row[128 + 32 * s +: 32] = 32'(cnt[s]);
            if (r < ndata) begin
                for (int j = 0; j < 64; j++)
                    if (64 * r + j < nsym) row[2 * j +: 2] = 2'(syms[64 * r + j]);
            end
            exp_addr.push_back(ADDR_W'(r));
            exp_data.push_back(row);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 256'(bus.sym_ready), 256'(0));
        check({tag, "_wr_en"}, 256'(bus.wr_en),     256'(0));
        check({tag, "_addr"},  256'(bus.wr_addr),   256'(0));
        check({tag, "_data"},  bus.wr_data,         256'(0));
        check({tag, "_busy"},  256'(bus.busy),      256'(0));
        check({tag, "_done"},  256'(bus.done),      256'(0));
        check({tag, "_err"},   256'(bus.err),       256'(0));
    endtask

    // mode: 0 random, 1 ACGT repeating, 2 all G, 3 all T
    task automatic run_build(input string name, input int nsym, input int mode,
                             input bit gaps, input bit poke_start, input int rst_at);
        int  k = 0, bubbles = 0, rdy_hi = 0, n_cyc = 0;
        bit  pend = 1'b0, seen_ready = 1'b0, got_done = 1'b0, did_rst = 1'b0, vld;
        syms.delete();
        for (int i = 0; i < nsym; i++) begin
            case (mode)
                1:       syms.push_back(i % 4);
                2:       syms.push_back(2);
                3:       syms.push_back(3);
                default: syms.push_back(int'($urandom_range(0, 3)));
            endcase
        end
        cap_addr.delete();
        cap_data.delete();
        done_cnt = 0; zero_viol = 0; last_wr_cyc = 0; done_cyc = 0;

        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check({name, "_busy_after_start"}, 256'(bus.busy), 256'(1));

        while (1) begin
            if (pend) k++;
            if (bus.done) begin got_done = 1'b1; break; end
            if (rst_at >= 0 && k == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_outputs_zero({name, "_rst"});
`ifdef OCC_STATS_EN
                check({name, "_rst_total"}, 256'(bus.total_syms), 256'(0));
`endif
                bus.sym_valid = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                check({name, "_rst_no_write"}, 256'(cap_addr.size()), 256'(0));
                did_rst = 1'b1;
                break;
            end
            if (bus.sym_ready) seen_ready = 1'b1;
            else if (seen_ready && k < nsym && bus.busy) bubbles++;
            vld = (k < nsym) && (!gaps || $urandom_range(0, 3) != 0);
            bus.sym_valid = vld;
            bus.sym_data  = (k < nsym) ? 2'(syms[k]) : 2'd0;
            bus.sym_last  = (k == nsym - 1);
            bus.start     = poke_start && (k == 5);
            pend = vld && bus.sym_ready;
            @(negedge clk);
            n_cyc++;
            if (n_cyc > 4000) break;
        end
        bus.start = 1'b0;
        if (did_rst) return;
        check({name, "_done_seen"}, 256'(got_done), 256'(1));

        // Upstream keeps offering symbols; none may be taken after done.
        for (int i = 0; i < 3; i++) begin
            bus.sym_valid = (k < nsym);
            @(negedge clk);
            if (bus.sym_ready) rdy_hi++;
        end
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        repeat (2) @(negedge clk);

        build_model(nsym);
        check({name, "_nwrites"},  256'(cap_addr.size()), 256'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 256'(cap_addr[i]), 256'(exp_addr[i]));
            check($sformatf("%s_row%0d", name, i), cap_data[i], exp_data[i]);
        end
        check({name, "_err"},         256'(bus.err),  256'(exp_err));
        check({name, "_consumed"},    256'(k),        256'(exp_consumed));
        check({name, "_done_pulses"}, 256'(done_cnt), 256'(1));
        check({name, "_idle_zero"},   256'(zero_viol), 256'(0));
        check({name, "_busy_end"},    256'(bus.busy), 256'(0));
        check({name, "_ready_after"}, 256'(rdy_hi),   256'(0));
        if (!exp_err)
            check({name, "_done_lat"}, 256'(done_cyc - last_wr_cyc), 256'(1));
        if (!gaps && exp_consumed == nsym)
            check({name, "_bubbles"}, 256'(bubbles), 256'((nsym - 1) / 64));
`ifdef OCC_STATS_EN
        check({name, "_total_syms"},   256'(bus.total_syms),   256'(exp_consumed));
        check({name, "_rows_written"}, 256'(bus.rows_written), 256'(exp_addr.size()));
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_data  = 2'd0;
        bus.sym_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_build("acgt10",  10,  1, 1'b0, 1'b0, -1);
        run_build("g64",     64,  2, 1'b0, 1'b0, -1);
        run_build("t130",    130, 3, 1'b0, 1'b0, -1);
        run_build("ovf_term", 200, 0, 1'b0, 1'b0, -1);
        run_build("ovf_data", 300, 0, 1'b0, 1'b0, -1);
        run_build("ovf_256", 256, 0, 1'b0, 1'b0, -1);
        run_build("midrst",  100, 0, 1'b0, 1'b0, 30);
        run_build("after_rst", 5, 0, 1'b0, 1'b0, -1);
        for (int t = 0; t < 6; t++)
            run_build($sformatf("rnd%0d", t), int'($urandom_range(1, 250)), 0,
                      1'b1, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
